// File: rtl/mmio_data_responder.sv
// Data-memory responder for the CPU MEM stage: word RAM plus memory-mapped
// LED, switch, timer and 8-digit 7-segment scanner registers.
module mmio_data_responder #(
  parameter int ADDR_W   = 12,
  parameter int SCAN_DIV = 20000,
  parameter int TMR_DIV  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_en_o,
  output logic [6:0]  seg_o
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int TMR_W  = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TMR_DIV - 1);

  // Word addresses (byte address >> 2) of the peripheral registers
  localparam logic [29:0] A_DIG = 30'h3FFF_FC00;
  localparam logic [29:0] A_TMR = 30'h3FFF_FC08;
  localparam logic [29:0] A_LED = 30'h3FFF_FC18;
  localparam logic [29:0] A_SW  = 30'h3FFF_FC1C;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [29:0]       waddr;
  logic              sel_ram;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       dig_q;
  logic [31:0]       tmr_q;
  logic [TMR_W-1:0]  presc_q;
  logic [SCAN_W-1:0] scan_q;
  logic [2:0]        dig_idx;
  logic [23:0]       sw_s1, sw_s2;
  logic              unused_bits;

  assign waddr       = addr_i[31:2];
  assign sel_ram     = (addr_i[31:ADDR_W+2] == '0);
  assign ram_idx     = addr_i[ADDR_W+1:2];
  assign unused_bits = &{1'b0, addr_i[1:0]};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // RAM is not reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (we_i && sel_ram && rst_n)
      ram[ram_idx] <= wdata_i;
  end

  always_comb begin
    rdata_o = 32'h0;
    if (sel_ram)              rdata_o = ram[ram_idx];
    else if (waddr == A_DIG)  rdata_o = dig_q;
    else if (waddr == A_TMR)  rdata_o = tmr_q;
    else if (waddr == A_LED)  rdata_o = {8'h0, led_o};
    else if (waddr == A_SW)   rdata_o = {8'h0, sw_s2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o <= '0;
      dig_q <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      if (we_i && waddr == A_LED) led_o <= wdata_i[23:0];
      if (we_i && waddr == A_DIG) dig_q <= wdata_i;
    end
  end

  // A timer write wins over a coincident prescaler wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q   <= '0;
      presc_q <= '0;
    end else if (we_i && waddr == A_TMR) begin
      tmr_q   <= wdata_i;
      presc_q <= '0;
    end else if (presc_q == TMR_LAST) begin
      tmr_q   <= tmr_q + 32'd1;
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q   <= '0;
      dig_idx  <= '0;
      seg_en_o <= 8'hFE;
      seg_o    <= 7'h40;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q  <= '0;
        dig_idx <= dig_idx + 3'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      seg_en_o <= ~(8'b1 << dig_idx);
      seg_o    <= hex7(dig_q[{dig_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_mmio_data_responder.sv
// Directed bench for mmio_data_responder; expected values flow through a
// scoreboard queue and are checked with immediate assertions.
module tb_mmio_data_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic [31:0] rdata_o;
  logic [23:0] sw_i;
  logic [23:0] led_o;
  logic [7:0]  seg_en_o;
  logic [6:0]  seg_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] DIG = 32'hFFFF_F000;
  localparam logic [31:0] TMR = 32'hFFFF_F020;
  localparam logic [31:0] LED = 32'hFFFF_F060;
  localparam logic [31:0] SW  = 32'hFFFF_F070;

  logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  mmio_data_responder #(.ADDR_W(8), .SCAN_DIV(2), .TMR_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
    .rdata_o(rdata_o), .sw_i(sw_i), .led_o(led_o), .seg_en_o(seg_en_o), .seg_o(seg_o)
  );

  always #10 clk = ~clk;

  task automatic push_exp(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    push_exp(e);
    addr_i = a;
    we_i   = 1'b0;
    #1;
    chk(tag, rdata_o);
  endtask

  // Called just after a falling edge; the store lands on the next rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    @(negedge clk);
    we_i    = 1'b0;
  endtask

  initial begin
    logic [7:0] prev_en;
    logic       found;
    logic [31:0] dig_val;
    logic [3:0] nib;

    rst_n = 1'b0; addr_i = '0; wdata_i = '0; we_i = 1'b0; sw_i = '0;
    repeat (3) @(negedge clk);
    push_exp(32'h0);  chk("rst_led", {8'h0, led_o});
    push_exp(32'hFE); chk("rst_seg_en", {24'h0, seg_en_o});
    push_exp(32'h40); chk("rst_seg", {25'h0, seg_o});
    load_chk("rst_tmr", TMR, 32'h0);
    rst_n = 1'b1;

    // Timer from reset: TMR_DIV=4, so 12 edges give 3 increments
    repeat (12) @(negedge clk);
    load_chk("tmr_after_12", TMR, 32'd3);
    @(negedge clk);
    store(TMR, 32'hFFFF_FFFF);
    load_chk("tmr_loaded", TMR, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    load_chk("tmr_hold_3", TMR, 32'hFFFF_FFFF);
    @(negedge clk);
    load_chk("tmr_wrap", TMR, 32'h0);
    repeat (3) @(negedge clk);
    store(TMR, 32'h0000_00A5);
    load_chk("tmr_wr_prio", TMR, 32'h0000_00A5);
    repeat (3) @(negedge clk);
    load_chk("tmr_presc_clr", TMR, 32'h0000_00A5);
    @(negedge clk);
    load_chk("tmr_inc_after", TMR, 32'h0000_00A6);

    // RAM
    store(32'h10, 32'hDEAD_BEEF);
    store(32'h14, 32'h1234_5678);
    store(32'h00, 32'h0000_0055);
    load_chk("ram_10", 32'h10, 32'hDEAD_BEEF);
    load_chk("ram_13", 32'h13, 32'hDEAD_BEEF);
    load_chk("ram_14", 32'h14, 32'h1234_5678);
    addr_i = 32'h10; wdata_i = 32'hCAFE_F00D; we_i = 1'b1;
    push_exp(32'hDEAD_BEEF);
    #1 chk("ram_same_cycle_old", rdata_o);
    @(negedge clk);
    we_i = 1'b0;
    load_chk("ram_next_cycle_new", 32'h10, 32'hCAFE_F00D);

    // LED and switches
    store(LED, 32'hFFAB_CDEF);
    push_exp(32'h00AB_CDEF); chk("led_out", {8'h0, led_o});
    load_chk("led_read", LED, 32'h00AB_CDEF);
    sw_i = 24'h00A5A5;
    @(negedge clk);
    load_chk("sw_1edge_old", SW, 32'h0);
    repeat (2) @(negedge clk);
    load_chk("sw_3edge_new", SW, 32'h0000_A5A5);
    store(SW, 32'hFFFF_FFFF);
    load_chk("sw_write_ignored", SW, 32'h0000_A5A5);

    // Display scan
    dig_val = 32'h8765_4321;
    store(DIG, dig_val);
    load_chk("dig_read", DIG, dig_val);
    prev_en = seg_en_o;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (seg_en_o == 8'hFE && prev_en != 8'hFE) found = 1'b1;
      prev_en = seg_en_o;
    end
    push_exp(32'h1); chk("scan_sync", {31'h0, found});
    for (int k = 0; k < 9; k++) begin
      nib = dig_val[4*(k%8) +: 4];
      push_exp({24'h0, ~(8'h1 << (k % 8))}); chk($sformatf("seg_en_%0d", k), {24'h0, seg_en_o});
      push_exp({25'h0, seg_tab[nib]});       chk($sformatf("seg_%0d", k), {25'h0, seg_o});
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset mid-cycle
    store(TMR, 32'h0000_1000);
    #3 rst_n = 1'b0;
    #1;
    push_exp(32'h0);  chk("mid_rst_led", {8'h0, led_o});
    push_exp(32'hFE); chk("mid_rst_seg_en", {24'h0, seg_en_o});
    push_exp(32'h40); chk("mid_rst_seg", {25'h0, seg_o});
    load_chk("mid_rst_tmr", TMR, 32'h0);
    load_chk("mid_rst_dig", DIG, 32'h0);
    load_chk("mid_rst_sw", SW, 32'h0);
    @(negedge clk);
    store(LED, 32'h0000_0777);
    push_exp(32'h0); chk("rst_store_lost", {8'h0, led_o});
    rst_n = 1'b1;
    load_chk("ram_kept_over_rst", 32'h10, 32'hCAFE_F00D);

    // Unmapped address
    store(LED, 32'h0000_0123);
    store(32'h8000_0000, 32'h0000_1234);
    load_chk("unmapped_read", 32'h8000_0000, 32'h0);
    load_chk("unmapped_ram0", 32'h0, 32'h0000_0055);
    load_chk("unmapped_led", LED, 32'h0000_0123);
    load_chk("unmapped_dig", DIG, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
